// File: rtl/batch_pkg.sv
// -----------------------------------------------------------------------------
// batch_pkg
// Shared definitions for the batch sample scheduler:
//   - NB           : number of rotating single-batch banks (4 with lookahead,
//                    3 without)
//   - FWD_OFS      : distance in banks between the bank being written and the
//                    bank replayed on the forward/backward streams. It is also
//                    the number of complete batches needed before warm.
//   - LH_OFS       : distance in banks to the lookahead bank
//   - bank_idx_t   : bank index type
//   - strm_t       : stream bundle {fwd, bwd, lh, valid, start, sel}. The
//                    sample fields are N_MAX bits wide; narrower samples are
//                    carried zero-extended.
//   - bank_back()  : (b - ofs) mod NB
//   - bank_next()  : (b + 1) mod NB
// Optional feature macro: BATCH_LOOKAHEAD_EN
// -----------------------------------------------------------------------------
package batch_pkg;

`ifdef BATCH_LOOKAHEAD_EN
   localparam int NB = 4;
`else
   localparam int NB = 3;
`endif

   localparam int FWD_OFS = NB - 2;
   localparam int LH_OFS  = 1;
   localparam int N_MAX   = 16;

   typedef logic [1:0] bank_idx_t;

   typedef struct packed {
      logic [N_MAX-1:0] fwd;
      logic [N_MAX-1:0] bwd;
      logic [N_MAX-1:0] lh;
      logic             valid;
      logic             start;
      logic             sel;
   } strm_t;

   // Bank that was written ofs batches ago.
   function automatic bank_idx_t bank_back(input bank_idx_t b, input int ofs);
      int t;
      t = (int'(b) + NB - ofs) % NB;
      return bank_idx_t'(t);
   endfunction

   function automatic bank_idx_t bank_next(input bank_idx_t b);
      return (int'(b) == NB - 1) ? '0 : b + 2'd1;
   endfunction

endpackage

// File: rtl/batch_sample_scheduler_if.sv
// -----------------------------------------------------------------------------
// batch_sample_scheduler_if
// Groups the sample input and the three replay streams of the batch
// scheduler into one interface.
//   in, in_valid            : control sample and its accept qualifier
//   s_fwd, s_bwd, s_lh      : forward / backward / lookahead stream samples
//   smp_valid, batch_start  : stream qualifier and first-sample-of-batch strobe
//   part_sel                : part-result double-buffer select
//   fwd_addr, bwd_addr      : part-result write addresses
//   warm                    : sticky "enough batches buffered"
// Modports: master (sample source / stream consumer), slave (scheduler).
// -----------------------------------------------------------------------------
interface batch_sample_scheduler_if #(
   parameter int DEPTH = 32,
   parameter int N     = 3
);
   localparam int AW = $clog2(DEPTH);

   logic [N-1:0]  in;
   logic          in_valid;
   logic [N-1:0]  s_fwd;
   logic [N-1:0]  s_bwd;
   logic [N-1:0]  s_lh;
   logic          smp_valid;
   logic          batch_start;
   logic          part_sel;
   logic [AW-1:0] fwd_addr;
   logic [AW-1:0] bwd_addr;
   logic          warm;

   modport master (
      output in, in_valid,
      input  s_fwd, s_bwd, s_lh, smp_valid, batch_start, part_sel,
             fwd_addr, bwd_addr, warm
   );

   modport slave (
      input  in, in_valid,
      output s_fwd, s_bwd, s_lh, smp_valid, batch_start, part_sel,
             fwd_addr, bwd_addr, warm
   );
endinterface

// File: rtl/batch_bank.sv
// -----------------------------------------------------------------------------
// batch_bank
// One DEPTH x N synchronous RAM holding a single batch of control samples.
// One write port and two registered read ports sharing one read enable.
// Read data holds while i_re is low, so stalls freeze the streams.
// Ports:
//   clk                  : clock
//   i_we, i_waddr, i_wdata : write port
//   i_re                 : read enable for both read ports
//   i_raddr_a, o_rdata_a : read port A (ascending replay)
//   i_raddr_b, o_rdata_b : read port B (descending replay)
// -----------------------------------------------------------------------------
module batch_bank #(
   parameter int DEPTH = 32,
   parameter int N     = 3
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [N-1:0]             i_wdata,
   input  logic                     i_re,
   input  logic [$clog2(DEPTH)-1:0] i_raddr_a,
   input  logic [$clog2(DEPTH)-1:0] i_raddr_b,
   output logic [N-1:0]             o_rdata_a,
   output logic [N-1:0]             o_rdata_b
);

   logic [N-1:0] r_mem [DEPTH];
   logic [N-1:0] r_rdata_a;
   logic [N-1:0] r_rdata_b;

   // Storage and read registers carry data only; no reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata_a <= r_mem[i_raddr_a];
         r_rdata_b <= r_mem[i_raddr_b];
      end
   end

   assign o_rdata_a = r_rdata_a;
   assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/batch_sample_scheduler.sv
// -----------------------------------------------------------------------------
// batch_sample_scheduler
// Buffers accepted control samples into NB rotating single-batch banks and
// replays earlier batches as three aligned streams:
//   s_fwd : batch k-FWD_OFS, ascending address
//   s_bwd : batch k-FWD_OFS, descending address
//   s_lh  : batch k-1, descending address (lookahead build only, else 0)
// together with part-result addresses, a batch_start strobe, a part-result
// double-buffer select and a sticky warm flag. All stream-side outputs appear
// one cycle after the accept that produced them. in_valid=0 freezes all
// counters and stream data.
// Optional feature macro: BATCH_LOOKAHEAD_EN (NB=4, lookahead stream on,
// warm after 2 batches). Default build: NB=3, s_lh tied to 0, warm after
// 1 batch.
// Ports:
//   clk    : clock
//   rst    : asynchronous active-low reset
//   io_bus : batch_sample_scheduler_if.slave (sample input and stream outputs)
// -----------------------------------------------------------------------------
module batch_sample_scheduler
   import batch_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int N     = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   batch_sample_scheduler_if.slave io_bus
);

   localparam int            AW      = $clog2(DEPTH);
   localparam logic [AW-1:0] C_LAST  = AW'(DEPTH - 1);
   localparam logic [1:0]    K_WARM  = 2'(FWD_OFS);
   // The streamed batch lags the written batch by FWD_OFS batches, so its
   // parity differs from the write parity by FWD_OFS mod 2.
   localparam logic          PAR_OFS = ((FWD_OFS % 2) == 1);

   // Write-side control state
   logic [AW-1:0] r_c;
   bank_idx_t     r_b;
   logic [1:0]    r_k;
   logic          r_par;
   logic          r_warm;

   // Stream-side registers (one cycle after the accept)
   logic          r_vld;
   logic          r_start;
   logic          r_sel;
   logic [AW-1:0] r_fa;
   logic [AW-1:0] r_ba;
   bank_idx_t     r_bsel_fwd;
`ifdef BATCH_LOOKAHEAD_EN
   bank_idx_t     r_bsel_lh;
`endif

   logic          w_acc;
   logic          w_warm_acc;
   logic [N-1:0]  w_rd_a [NB];
   logic [N-1:0]  w_rd_b [NB];

   assign w_acc      = io_bus.in_valid;
   // k has already counted the completed batches when the first sample of
   // the next batch is accepted, so this accept is the first one streamed.
   assign w_warm_acc = (r_k >= K_WARM);

   // ---- Accept stage: write current bank, launch reads of older banks ----
   // All banks read address c on port A and DEPTH-1-c on port B; the bank
   // actually used is picked after the read registers, using the bank
   // selects captured on the same accept.
   for (genvar g = 0; g < NB; g++) begin : g_bank
      batch_bank #(
         .DEPTH (DEPTH),
         .N     (N)
      ) u_bank (
         .clk       (clk),
         .i_we      (w_acc && (r_b == bank_idx_t'(g))),
         .i_waddr   (r_c),
         .i_wdata   (io_bus.in),
         .i_re      (w_acc),
         .i_raddr_a (r_c),
         .i_raddr_b (~r_c),
         .o_rdata_a (w_rd_a[g]),
         .o_rdata_b (w_rd_b[g])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_c        <= '0;
         r_b        <= '0;
         r_k        <= '0;
         r_par      <= 1'b0;
         r_warm     <= 1'b0;
         r_vld      <= 1'b0;
         r_start    <= 1'b0;
         r_sel      <= 1'b0;
         r_fa       <= '0;
         r_ba       <= '0;
         r_bsel_fwd <= '0;
`ifdef BATCH_LOOKAHEAD_EN
         r_bsel_lh  <= '0;
`endif
      end else begin
         r_vld   <= w_acc && w_warm_acc;
         r_start <= w_acc && w_warm_acc && (r_c == '0);
         if (w_acc) begin
            r_c        <= r_c + 1'b1;
            r_bsel_fwd <= bank_back(r_b, FWD_OFS);
`ifdef BATCH_LOOKAHEAD_EN
            r_bsel_lh  <= bank_back(r_b, LH_OFS);
`endif
            if (r_c == C_LAST) begin
               r_b   <= bank_next(r_b);
               r_par <= ~r_par;
               if (r_k != 2'd3) begin
                  r_k <= r_k + 2'd1;
               end
            end
            // Addresses and select only move once streaming has begun,
            // so they read 0 until the first valid sample.
            if (w_warm_acc) begin
               r_warm <= 1'b1;
               r_fa   <= r_c;
               r_ba   <= ~r_c;
               r_sel  <= r_par ^ PAR_OFS;
            end
         end
      end
   end

   // ---- Stream stage: pick the replayed banks, blank until warm ----
   always_comb begin
      io_bus.s_fwd = '0;
      io_bus.s_bwd = '0;
      io_bus.s_lh  = '0;
      if (r_warm) begin
         io_bus.s_fwd = w_rd_a[r_bsel_fwd];
         io_bus.s_bwd = w_rd_b[r_bsel_fwd];
`ifdef BATCH_LOOKAHEAD_EN
         io_bus.s_lh  = w_rd_b[r_bsel_lh];
`endif
      end
   end

   assign io_bus.smp_valid   = r_vld;
   assign io_bus.batch_start = r_start;
   assign io_bus.part_sel    = r_sel;
   assign io_bus.fwd_addr    = r_fa;
   assign io_bus.bwd_addr    = r_ba;
   assign io_bus.warm        = r_warm;

endmodule
